// File: rtl/divider_4_bit_seq.sv
// Sequential restoring unsigned divider, one quotient bit per clock, start/busy/done handshake.
// Optional macro DIV_ZERO_EARLY_EN: a zero divisor completes one cycle after acceptance and flags div_by_zero.
module divider_4_bit_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZERO = 2'd2
    } state_t;

    state_t state_r;
    state_t state_s;

    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH:0]   part_r;
    logic [WIDTH-1:0] quo_r;
    logic [CW-1:0]    count_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;

    logic             accept_s;
    logic             finish_s;
    logic [WIDTH:0]   shift_s;
    logic [WIDTH:0]   rem_next_s;
    logic             qbit_s;
    logic [WIDTH-1:0] quo_next_s;
`ifdef DIV_ZERO_EARLY_EN
    logic             zero_fin_s;
    logic             dbz_r;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and handshake control
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        finish_s = 1'b0;
`ifdef DIV_ZERO_EARLY_EN
        zero_fin_s = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
`ifdef DIV_ZERO_EARLY_EN
                    if (divisor == {WIDTH{1'b0}}) begin
                        state_s = ZERO;
                    end else begin
                        state_s = RUN;
                    end
`else
                    state_s = RUN;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (count_r == CW'(1)) begin
                    finish_s = 1'b1;
                    state_s  = IDLE;
                end else begin
                    state_s = RUN;
                end
            end
`ifdef DIV_ZERO_EARLY_EN
            ZERO: begin
                zero_fin_s = 1'b1;
                state_s    = IDLE;
            end
`endif
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // One restoring iteration: shift in next dividend bit, subtract when it fits
    always_comb begin
        shift_s = {part_r[WIDTH-1:0], dvd_r[WIDTH-1]};
        if (shift_s >= {1'b0, dvs_r}) begin
            rem_next_s = shift_s - {1'b0, dvs_r};
            qbit_s     = 1'b1;
        end else begin
            rem_next_s = shift_s;
            qbit_s     = 1'b0;
        end
        quo_next_s = {quo_r[WIDTH-2:0], qbit_s};
    end

    // Working registers, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_r       <= {WIDTH{1'b0}};
            dvs_r       <= {WIDTH{1'b0}};
            part_r      <= {(WIDTH+1){1'b0}};
            quo_r       <= {WIDTH{1'b0}};
            count_r     <= {CW{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
`ifdef DIV_ZERO_EARLY_EN
            dbz_r       <= 1'b0;
`endif
        end else begin
            if (accept_s) begin
                dvd_r   <= dividend;
                dvs_r   <= divisor;
                part_r  <= {(WIDTH+1){1'b0}};
                quo_r   <= {WIDTH{1'b0}};
                count_r <= CW'(WIDTH);
            end else if (state_r == RUN) begin
                dvd_r   <= {dvd_r[WIDTH-2:0], 1'b0};
                part_r  <= rem_next_s;
                quo_r   <= quo_next_s;
                count_r <= count_r - CW'(1);
            end
            busy_r <= (state_s == RUN);
`ifdef DIV_ZERO_EARLY_EN
            done_r <= finish_s | zero_fin_s;
            if (zero_fin_s) begin
                // dvd_r still holds the unshifted dividend here
                quotient_r  <= {WIDTH{1'b1}};
                remainder_r <= dvd_r;
                dbz_r       <= 1'b1;
            end else if (finish_s) begin
                quotient_r  <= quo_next_s;
                remainder_r <= rem_next_s[WIDTH-1:0];
                dbz_r       <= 1'b0;
            end
`else
            done_r <= finish_s;
            if (finish_s) begin
                quotient_r  <= quo_next_s;
                remainder_r <= rem_next_s[WIDTH-1:0];
            end
`endif
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign quotient  = quotient_r;
    assign remainder = remainder_r;
`ifdef DIV_ZERO_EARLY_EN
    assign div_by_zero = dbz_r;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_divider_4_bit_seq.sv
// Self-checking bench for divider_4_bit_seq: directed edge cases, exhaustive back-to-back sweep,
// random operations, protocol and mid-operation reset, all against an arithmetic reference model.
module tb_divider_4_bit_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int errors = 0;
    int checks = 0;

`ifdef DIV_ZERO_EARLY_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    divider_4_bit_seq #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, with the zero-divisor conventions
    task automatic model(input logic [3:0] a, input logic [3:0] b,
                         output logic [3:0] q, output logic [3:0] r,
                         output logic dz, output int lat);
        if (b == 4'd0) begin
            q   = 4'd15;
            r   = a;
            dz  = EARLY;
            lat = EARLY ? 1 : 4;
        end else begin
            q   = 4'(int'(a) / int'(b));
            r   = 4'(int'(a) % int'(b));
            dz  = 1'b0;
            lat = 4;
        end
    endtask

    // Issue one operation and check busy/done timing and results; returns in the done cycle
    task automatic run_op(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] eq;
        logic [3:0] er;
        logic       edz;
        int         lat;
        model(a, b, eq, er, edz, lat);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("accept_done", 32'(done), 32'(0));
        check("accept_busy", 32'(busy), 32'(lat > 1));
        for (int c = 1; c <= lat; c++) begin
            @(posedge clk);
            #1;
            if (c < lat) begin
                check("run_done", 32'(done), 32'(0));
                check("run_busy", 32'(busy), 32'(1));
            end else begin
                check("fin_done", 32'(done), 32'(1));
                check("fin_busy", 32'(busy), 32'(0));
                check("quotient", 32'(quotient), 32'(eq));
                check("remainder", 32'(remainder), 32'(er));
                check("div_by_zero", 32'(div_by_zero), 32'(edz));
            end
        end
    endtask

    initial begin
        int dones;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;
        #1;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_q", 32'(quotient), 32'(0));
        check("rst_r", 32'(remainder), 32'(0));
        check("rst_dbz", 32'(div_by_zero), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(4'd13, 4'd3);

        // Mid-operation reset two cycles into 13/3
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd13;
        divisor  = 4'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("mrst_busy", 32'(busy), 32'(0));
        check("mrst_done", 32'(done), 32'(0));
        check("mrst_q", 32'(quotient), 32'(0));
        check("mrst_r", 32'(remainder), 32'(0));
        check("mrst_dbz", 32'(div_by_zero), 32'(0));
        repeat (3) begin
            @(posedge clk);
            #1;
            check("mrst_no_done", 32'(done), 32'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("post_rst_no_done", 32'(done), 32'(0));
        end
        run_op(4'd6, 4'd4);

        // Edge values and divide by zero
        run_op(4'd15, 4'd1);
        run_op(4'd7, 4'd9);
        run_op(4'd0, 4'd5);
        run_op(4'd15, 4'd15);
        run_op(4'd9, 4'd0);

        // Exhaustive sweep, each start issued in the previous done cycle
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_op(4'(a), 4'(b));
            end
        end

        // Random operations, zero divisor included
        repeat (40) begin
            run_op(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
        end

        // Protocol: start held, operands scrambled while busy
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd11;
        divisor  = 4'd2;
        dones    = 0;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            dividend = 4'($urandom_range(15, 0));
            divisor  = 4'($urandom_range(15, 0));
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        start = 1'b0;
        check("proto_q", 32'(quotient), 32'(5));
        check("proto_r", 32'(remainder), 32'(1));
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("proto_one_done", 32'(dones), 32'(1));
        check("proto_idle", 32'(busy), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
